// File: rtl/bnn_pkg.sv
// bnn_pkg: shared top-level state encoding and network geometry constants
package bnn_pkg;
  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_LOAD    = 3'd1,
    s_LAYER_1 = 3'd2,
    s_LAYER_2 = 3'd3,
    s_LAYER_3 = 3'd4
  } state_t;
  localparam int IMG_DIM   = 28;
  localparam int N_KERN    = 8;
  localparam int KERN_DIM  = 3;
  localparam int WGT_BEATS = 9;
  localparam int PIX_BEATS = 98;
endpackage

// File: rtl/stream_xor_check.sv
// stream_xor_check: running XOR of accepted beats, compared against a final checksum beat
module stream_xor_check #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic         match
);
  logic [W-1:0] acc;
  // accumulate every payload beat; cleared between loads
  always_ff @(posedge clk)
    if (!rst_n || clr) acc <= '0;
    else if (en) acc <= acc ^ data;
  assign match = acc == data;
endmodule

// File: rtl/pixel_loader.sv
// pixel_loader: deserialises the load byte stream into binary kernels and image; optional checksum via LOADER_CHECKSUM_EN
module pixel_loader
  import bnn_pkg::*;
#(
  parameter int BEAT_W = 8
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  state_t                                              state,
  input  logic                                                in_valid,
  input  logic [BEAT_W-1:0]                                   in_data,
  output logic                                                in_ready,
  output logic [IMG_DIM-1:0][IMG_DIM-1:0]                     pixels,
  output logic [N_KERN-1:0][KERN_DIM-1:0][KERN_DIM-1:0]       weights,
  output logic                                                done,
  output logic                                                load_err
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {L_IDLE, L_WGT, L_PIX, L_CHK, L_DONE} ls_t;
`else
  typedef enum logic [2:0] {L_IDLE, L_WGT, L_PIX, L_DONE} ls_t;
`endif
  ls_t ls;
  logic [6:0] cnt;
  logic [N_KERN*KERN_DIM*KERN_DIM-1:0] wgt_q;
  logic [IMG_DIM*IMG_DIM-1:0] pix_q;
  logic acc;
  logic last_w, last_p;
`ifdef LOADER_CHECKSUM_EN
  logic ck_ok;
  assign in_ready = (ls == L_WGT || ls == L_PIX || ls == L_CHK) && state == s_LOAD;
  stream_xor_check #(.W(BEAT_W)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ls == L_IDLE),
    .en    (acc && ls != L_CHK),
    .data  (in_data),
    .match (ck_ok)
  );
`else
  assign in_ready = (ls == L_WGT || ls == L_PIX) && state == s_LOAD;
  assign load_err = 1'b0;
`endif
  assign acc    = in_valid && in_ready;
  assign last_w = cnt == 7'(WGT_BEATS - 1);
  assign last_p = cnt == 7'(PIX_BEATS - 1);
  // loader sequencing: phase, beat counter and sticky status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ls   <= L_IDLE;
      cnt  <= '0;
      done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      load_err <= 1'b0;
`endif
    end else if (state == s_IDLE && ls != L_IDLE) begin
      ls   <= L_IDLE;
      cnt  <= '0;
      done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      load_err <= 1'b0;
`endif
    end else begin
      case (ls)
        L_IDLE: if (state == s_LOAD) begin
          ls  <= L_WGT;
          cnt <= '0;
        end
        L_WGT: if (acc) begin
          ls  <= last_w ? L_PIX : L_WGT;
          cnt <= last_w ? '0 : cnt + 7'd1;
        end
        L_PIX: if (acc) begin
          cnt <= last_p ? '0 : cnt + 7'd1;
`ifdef LOADER_CHECKSUM_EN
          ls  <= last_p ? L_CHK : L_PIX;
`else
          ls   <= last_p ? L_DONE : L_PIX;
          done <= last_p;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        L_CHK: if (acc) begin
          ls       <= L_DONE;
          done     <= 1'b1;
          load_err <= !ck_ok;
        end
`endif
        default: ;
      endcase
    end
  end
  // buffer writes: each accepted beat lands LSB-first at offset cnt*8 of its phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wgt_q <= '0;
      pix_q <= '0;
    end else if (acc && ls == L_WGT) wgt_q[{cnt[3:0], 3'b000} +: BEAT_W] <= in_data;
    else if (acc && ls == L_PIX) pix_q[{cnt, 3'b000} +: BEAT_W] <= in_data;
  end
  for (genvar r = 0; r < IMG_DIM; r++)
    for (genvar c = 0; c < IMG_DIM; c++)
      assign pixels[r][c] = pix_q[r*IMG_DIM+c];
  for (genvar n = 0; n < N_KERN; n++)
    for (genvar r = 0; r < KERN_DIM; r++)
      for (genvar c = 0; c < KERN_DIM; c++)
        assign weights[n][r][c] = wgt_q[n*KERN_DIM*KERN_DIM+r*KERN_DIM+c];
endmodule

// File: tb/tb_pixel_loader.sv
// tb_pixel_loader: table-driven and sequence checks of the pixel/weight loader
module tb_pixel_loader;
  import bnn_pkg::*;
`ifdef LOADER_CHECKSUM_EN
  localparam int NB = 108;
`else
  localparam int NB = 107;
`endif
  logic clk, rst_n, in_valid, in_ready, done, load_err;
  state_t state;
  logic [7:0] in_data;
  logic [IMG_DIM-1:0][IMG_DIM-1:0] pixels;
  logic [N_KERN-1:0][KERN_DIM-1:0][KERN_DIM-1:0] weights;
  logic [IMG_DIM-1:0][IMG_DIM-1:0] ep;
  logic [N_KERN-1:0][KERN_DIM-1:0][KERN_DIM-1:0] ew;
  logic [7:0] beats [0:107];
  int total = 0, bad = 0;

  typedef struct {
    logic [7:0] wfill, pfill;
    int b1; logic [7:0] v1;
    int b2; logic [7:0] v2;
    int wones, pones;
    int pr, pc, wn;
  } vec_t;
  vec_t vecs [5];

  pixel_loader #(.BEAT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pixels(pixels), .weights(weights), .done(done), .load_err(load_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic seal_checksum();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 107; i++) x ^= beats[i];
    beats[107] = x;
  endtask

  task automatic build_expect();
    for (int w = 0; w < 72; w++) ew[w/9][(w%9)/3][w%3] = beats[w/8][w%8];
    for (int p = 0; p < 784; p++) ep[p/28][p%28] = beats[9 + p/8][p%8];
  endtask

  task automatic cmp_arrays(input string nm);
    int e = 0;
    build_expect();
    for (int r = 0; r < IMG_DIM; r++)
      for (int c = 0; c < IMG_DIM; c++) if (pixels[r][c] !== ep[r][c]) e++;
    for (int n = 0; n < N_KERN; n++)
      for (int r = 0; r < KERN_DIM; r++)
        for (int c = 0; c < KERN_DIM; c++) if (weights[n][r][c] !== ew[n][r][c]) e++;
    chk(nm, e, 0);
  endtask

  task automatic go_idle(input string nm);
    state = s_IDLE;
    in_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_idle_done"}, done, 0);
    chk({nm, "_idle_err"}, load_err, 0);
    chk({nm, "_idle_ready"}, in_ready, 0);
  endtask

  task automatic run_load(input string nm, input bit rnd, input int gap_at, input int stop_at);
    int i = 0, cyc = 0, gap = 0, early = 0, gap_bad = 0;
    bit a;
    while (i < NB && i != stop_at && cyc < 3000) begin
      in_data = beats[i];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i == gap_at && gap < 5) begin
        state = s_LAYER_2;
        gap++;
      end else state = s_LOAD;
      @(negedge clk);
      if (state == s_LAYER_2 && in_ready) gap_bad++;
      if (done) early++;
      a = in_valid && in_ready;
      @(posedge clk); #1;
      if (a) i++;
      cyc++;
    end
    in_valid = 0;
    state = s_LOAD;
    if (stop_at < 0) begin
      chk({nm, "_beats"}, i, NB);
      chk({nm, "_done_early"}, early, 0);
      if (gap_at >= 0) begin
        chk({nm, "_gap_ready"}, gap_bad, 0);
        chk({nm, "_gap_len"}, gap, 5);
      end
      @(negedge clk);
      chk({nm, "_done"}, done, 1);
      chk({nm, "_ready_after"}, in_ready, 0);
    end else chk({nm, "_partial_beats"}, i, stop_at);
  endtask

  initial begin
    rst_n = 0; state = s_IDLE; in_valid = 0; in_data = 0;
    vecs[0] = '{8'hFF, 8'h00, -1, 8'h00, -1, 8'h00, 72, 0,   -1, 0, -1};
    vecs[1] = '{8'h00, 8'h00,  9, 8'h01, 12, 8'h10, 0,  2,    1, 0, -1};
    vecs[2] = '{8'h00, 8'h00,  1, 8'h02, -1, 8'h00, 1,  0,   -1, 0,  1};
    vecs[3] = '{8'hA5, 8'h3C, -1, 8'h00, -1, 8'h00, 36, 392, -1, 0, -1};
    vecs[4] = '{8'h00, 8'hFF, -1, 8'h00, -1, 8'h00, 0,  784, -1, 0, -1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_pix", $countones(pixels), 0);
    chk("rst_wgt", $countones(weights), 0);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 107; i++) beats[i] = (i < 9) ? vecs[v].wfill : vecs[v].pfill;
      if (vecs[v].b1 >= 0) beats[vecs[v].b1] = vecs[v].v1;
      if (vecs[v].b2 >= 0) beats[vecs[v].b2] = vecs[v].v2;
      seal_checksum();
      run_load($sformatf("vec%0d", v), 0, -1, -1);
      chk($sformatf("vec%0d_wones", v), $countones(weights), vecs[v].wones);
      chk($sformatf("vec%0d_pones", v), $countones(pixels), vecs[v].pones);
      chk($sformatf("vec%0d_err", v), load_err, 0);
      if (vecs[v].pr >= 0) chk($sformatf("vec%0d_pbit", v), pixels[vecs[v].pr][vecs[v].pc], 1);
      if (vecs[v].wn >= 0) chk($sformatf("vec%0d_wbit", v), weights[vecs[v].wn][0][0], 1);
      cmp_arrays($sformatf("vec%0d_arrays", v));
      go_idle($sformatf("vec%0d", v));
    end
    chk("vec1_p00", 32'(pixels[0][0]), 32'(vecs[4].pones == 784));

    for (int i = 0; i < 107; i++) beats[i] = 8'($urandom);
    seal_checksum();
    run_load("gap", 1, 40, -1);
    cmp_arrays("gap_arrays");
    go_idle("gap");

    for (int i = 0; i < 107; i++) beats[i] = 8'($urandom);
    run_load("abort", 0, -1, 50);
    go_idle("abort");
    for (int i = 0; i < 107; i++) beats[i] = 8'($urandom);
    seal_checksum();
    run_load("reload", 0, -1, -1);
    cmp_arrays("reload_arrays");
    go_idle("reload");

    run_load("rstmid", 0, -1, 20);
    state = s_IDLE;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rstmid_ready", in_ready, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_pix", $countones(pixels), 0);
    chk("rstmid_wgt", $countones(weights), 0);

`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 107; i++) beats[i] = 8'($urandom);
    seal_checksum();
    run_load("ck_good", 0, -1, -1);
    chk("ck_good_err", load_err, 0);
    go_idle("ck_good");
    beats[107] ^= 8'h01;
    run_load("ck_bad", 0, -1, -1);
    chk("ck_bad_err", load_err, 1);
    go_idle("ck_bad");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_loader.md
# pixel_loader

Writer side of the pixel/weight buffers read by the first convolution layer. Accepts a byte stream from the chip inputs during the top-level `s_LOAD` state and deserialises it into the 8 binary 3×3 kernels and the 28×28 binary image. It then raises `done` so the top-level FSM can advance to `s_LAYER_1`. The assembled arrays are held stable until the next load.

## Interface
Parameters:
- `BEAT_W`, 8: stream beat width in bits; fixed at 8, since the beat counts below are derived from it.

Ports (one clock; reset is synchronous and active-low):
- `clk` input, 1: system clock.
- `rst_n` input, 1: synchronous active-low reset.
- `state` input, 3: top-level state (`state_t` encoding).
- `in_valid` input, 1: `in_data` is valid this cycle.
- `in_data` input, 8: stream beat.
- `in_ready` output, 1: loader accepts a beat this cycle.
- `pixels` output, 28×28: `pixels[row][col]`, binary image.
- `weights` output, 8×3×3: `weights[n][r][c]`, binary kernels.
- `done` output, 1: load complete; sticky.
- `load_err` output, 1: checksum mismatch; only when `LOADER_CHECKSUM_EN` is defined, otherwise tied to 0.

## Operation
- Internal FSM states: `L_IDLE`, `L_WGT`, `L_PIX`, `L_CHK`, `L_DONE`. `L_CHK` exists only when `LOADER_CHECKSUM_EN` is defined.
- A beat is accepted when `in_valid && in_ready` is true at a rising edge of `clk`.
- `in_ready` = (FSM in `L_WGT`, `L_PIX` or `L_CHK`) && (`state == s_LOAD`). It is combinational from registers and `state` only, never from `in_valid`.
- Transitions:
  - `L_IDLE` → `L_WGT` when `state == s_LOAD`.
  - `L_WGT` → `L_PIX` after beat 8 is accepted (9 weight beats, beat indices 0–8).
  - `L_PIX` → `L_DONE` after pixel beat 97 is accepted (98 pixel beats). With the macro defined, `L_PIX` → `L_CHK` instead.
  - `L_CHK` → `L_DONE` after 1 checksum beat.
  - `L_DONE` → `L_IDLE` when `state == s_IDLE`.
- Bit mapping is LSB-first within each beat. Stream bit `i` = beat `i/8`, bit `i%8`.
  - Weight bit `w` (0..71) maps to `weights[w/9][(w%9)/3][w%3]`.
  - Pixel bit `p` (0..783) maps to `pixels[p/28][p%28]`.
- Beat counter: 7 bits, cleared on each phase change. Bit offset = counter×8.
- `done` is set on entry to `L_DONE` and cleared on entry to `L_IDLE`.
- Buffer contents are never cleared except by reset. A new load overwrites every bit.
- If `state` leaves `s_LOAD` mid-load (not `s_IDLE`): `in_ready` falls, and the counter and FSM hold. The load resumes at the same beat when `state` returns to `s_LOAD`.
- If `state == s_IDLE` mid-load: FSM → `L_IDLE`, counter cleared, partial data left in place.
- `in_valid` while `in_ready == 0`: ignored, no side effects.

## Timing
- Reset values: `in_ready` = 0, `done` = 0, `load_err` = 0, all `pixels` = 0, all `weights` = 0, FSM = `L_IDLE`, counter = 0.
- `in_ready` rises in the cycle after the first edge that sees `state == s_LOAD` in `L_IDLE`.
- Array bits written by an accepted beat are visible at the outputs the cycle after the accepting edge.
- `done` rises the cycle after the final beat is accepted (the last pixel beat, or the checksum beat when the macro is defined). `in_ready` is 0 in that same cycle.
- Minimum load: 107 accepting cycles (108 with the macro) plus 1 entry cycle.
- Reset asserted mid-load overrides everything: reset values apply at the next edge.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the pixels, one extra beat equal to the XOR of all 107 preceding beats.
  - A mismatch sets `load_err` on entry to `L_DONE`. `done` still asserts.
  - `load_err` clears with `done` on entry to `L_IDLE`, and on reset.
- Not defined: no `L_CHK` state, no XOR register, `load_err` tied to 0, 107-beat load.

## Structure
- Shared package `bnn_pkg` holds:
  - `state_t`: `s_IDLE` = 0, `s_LOAD` = 1, `s_LAYER_1` = 2, `s_LAYER_2` = 3, `s_LAYER_3` = 4.
  - Constants `IMG_DIM` = 28, `N_KERN` = 8, `KERN_DIM` = 3, `WGT_BEATS` = 9, `PIX_BEATS` = 98.
- The loader FSM state enum stays local to the module.
- One sub-module, `stream_xor_check`: a running XOR accumulator with compare. It is instantiated only under `LOADER_CHECKSUM_EN`.

## Test plan
- Reset, then `state = s_LOAD` with `in_valid` held high; 9 beats `0xFF`, then 98 beats `0x00` → all `weights` = 1, all `pixels` = 0, `done` = 1 one cycle after beat 107, `in_ready` = 0 thereafter.
- Pixel beat 0 = `0x01`, pixel beat 3 = `0x10`, others `0x00` → only `pixels[0][0]` and `pixels[1][0]` (bits 0 and 28) are 1.
- Weight beat 1 = `0x02` (bit 9), others 0 → only `weights[1][0][0]` = 1.
- `in_valid` toggled randomly, and `state` forced to `s_LAYER_2` for 5 cycles at beat 40 → `in_ready` = 0 during the gap, no beat lost; the final arrays match a golden model.
- `state = s_IDLE` at beat 50, then a full reload → counter restarts at 0, `done` clear until the new beat 107, arrays equal the second stream.
- With `LOADER_CHECKSUM_EN` defined: correct XOR beat → `done` = 1, `load_err` = 0; the same stream with the checksum XORed by `0x01` → `done` = 1, `load_err` = 1; `state = s_IDLE` → both cleared.
